// File: rtl/jellyvl_synctimer_adjuster.sv
// Converts a signed master-minus-local time error into paced +/-1 adjust pulses, or a one-shot hard set for large errors.
// Optional: define JELLYVL_SYNCTIMER_ADJUSTER_OVERRIDE_EN to let a new request replace a slew in progress.
module jellyvl_synctimer_adjuster #(
    parameter int unsigned TIMER_WIDTH    = 64,
    parameter int unsigned ERROR_WIDTH    = 32,
    parameter int unsigned INTERVAL_WIDTH = 16,
    parameter int unsigned SET_THRESHOLD  = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [INTERVAL_WIDTH-1:0] param_interval,
    input  logic [TIMER_WIDTH-1:0]    current_time,
    input  logic [ERROR_WIDTH-1:0]    correct_error,
    input  logic                      correct_valid,
    output logic                      correct_ready,
    output logic [TIMER_WIDTH-1:0]    set_time,
    output logic                      set_valid,
    output logic                      adjust_sign,
    output logic                      adjust_valid,
    input  logic                      adjust_ready,
    output logic                      busy,
    output logic [ERROR_WIDTH-1:0]    remaining
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [INTERVAL_WIDTH-1:0] wait_count, wait_count_next;
    logic                      correct_ready_next;
    logic [TIMER_WIDTH-1:0]    set_time_next;
    logic                      set_valid_next;
    logic                      adjust_sign_next;
    logic                      adjust_valid_next;
    logic                      busy_next;
    logic [ERROR_WIDTH-1:0]    remaining_next;

    logic                      accept;
    logic                      handshake;
    logic [ERROR_WIDTH-1:0]    error_abs;
    logic [ERROR_WIDTH-1:0]    remaining_dec;

    assign accept        = correct_valid & correct_ready;
    assign handshake     = adjust_valid & adjust_ready;
    // Unsigned magnitude: the most negative error maps to 2^(ERROR_WIDTH-1) without overflow.
    assign error_abs     = correct_error[ERROR_WIDTH-1] ? (ERROR_WIDTH'(0) - correct_error) : correct_error;
    assign remaining_dec = remaining - ERROR_WIDTH'(1);

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_count    <= '0;
            correct_ready <= 1'b1;
            set_time      <= '0;
            set_valid     <= 1'b0;
            adjust_sign   <= 1'b0;
            adjust_valid  <= 1'b0;
            busy          <= 1'b0;
            remaining     <= '0;
        end else begin
            state         <= state_next;
            wait_count    <= wait_count_next;
            correct_ready <= correct_ready_next;
            set_time      <= set_time_next;
            set_valid     <= set_valid_next;
            adjust_sign   <= adjust_sign_next;
            adjust_valid  <= adjust_valid_next;
            busy          <= busy_next;
            remaining     <= remaining_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next        = state;
        wait_count_next   = wait_count;
        set_time_next     = set_time;
        set_valid_next    = 1'b0;
        adjust_sign_next  = adjust_sign;
        adjust_valid_next = adjust_valid;
        busy_next         = busy;
        remaining_next    = remaining;

        case (state)
            ISSUE: begin
                if (!adjust_valid) begin
                    adjust_valid_next = 1'b1;
                end else if (handshake) begin
                    remaining_next = remaining_dec;
                    if (remaining_dec == '0) begin
                        state_next        = IDLE;
                        adjust_valid_next = 1'b0;
                        busy_next         = 1'b0;
                    end else if (param_interval == '0) begin
                        adjust_valid_next = 1'b1;
                    end else begin
                        state_next        = WAIT;
                        adjust_valid_next = 1'b0;
                        wait_count_next   = param_interval;
                    end
                end
            end
            WAIT: begin
                // Valid rises together with the return to ISSUE so the gap is exactly param_interval cycles.
                if (wait_count <= INTERVAL_WIDTH'(1)) begin
                    state_next        = ISSUE;
                    adjust_valid_next = 1'b1;
                    wait_count_next   = '0;
                end else begin
                    wait_count_next = wait_count - INTERVAL_WIDTH'(1);
                end
            end
            default: begin
            end
        endcase

`ifdef JELLYVL_SYNCTIMER_ADJUSTER_OVERRIDE_EN
        if (accept) begin
`else
        if (accept && state == IDLE) begin
`endif
            adjust_valid_next = 1'b0;
            wait_count_next   = '0;
            if (correct_error == '0) begin
                state_next     = IDLE;
                busy_next      = 1'b0;
                remaining_next = '0;
            end else if (error_abs > ERROR_WIDTH'(SET_THRESHOLD)) begin
                state_next     = IDLE;
                busy_next      = 1'b0;
                remaining_next = '0;
                set_valid_next = 1'b1;
                set_time_next  = current_time
                               + {{(TIMER_WIDTH-ERROR_WIDTH){correct_error[ERROR_WIDTH-1]}}, correct_error};
            end else begin
                state_next       = ISSUE;
                busy_next        = 1'b1;
                remaining_next   = error_abs;
                adjust_sign_next = correct_error[ERROR_WIDTH-1];
            end
        end

`ifdef JELLYVL_SYNCTIMER_ADJUSTER_OVERRIDE_EN
        correct_ready_next = 1'b1;
`else
        correct_ready_next = (state_next == IDLE);
`endif
    end

endmodule
